// File: rtl/imem_read_arbiter.sv
// Arbitrates the single instruction-side AXI read channel between I-cache demand refills
// and stream-buffer prefetches, one burst at a time, routing returned beats to the owner.
module imem_read_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int BURST_LEN    = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dem_arvalid,
   input  logic [ADDR_WIDTH-1:0] dem_araddr,
   output logic                  dem_arready,
   output logic                  dem_rvalid,
   output logic [DATA_WIDTH-1:0] dem_rdata,
   output logic                  dem_rlast,
   input  logic                  pf_arvalid,
   input  logic [ADDR_WIDTH-1:0] pf_araddr,
   output logic                  pf_arready,
   input  logic                  pf_cancel,
   output logic                  pf_rvalid,
   output logic [DATA_WIDTH-1:0] pf_rdata,
   output logic                  pf_rlast,
   output logic                  mem_arvalid,
   output logic [ADDR_WIDTH-1:0] mem_araddr,
   output logic [7:0]            mem_arlen,
   input  logic                  mem_arready,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_rlast,
   output logic                  mem_rready,
   output logic                  busy,
   output logic                  owner,
   output logic                  err
);

   localparam int CNT_W = $clog2(BURST_LEN) + 2;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [STV_W-1:0] STV_MAX   = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  owner_q, owner_d;
   logic [STV_W-1:0]      starve_q, starve_d;
   logic [CNT_W-1:0]      beat_q, beat_d;
   logic                  cancel_q, cancel_d;
   logic                  err_q, err_d;

   logic grant_pf;
   logic grant_dem;
   logic cancel_now;
   logic beat_go;

   // Grants are gated by rst_n so every handshake output is low while reset is held.
   always_comb begin
      grant_pf   = rst_n & (state_q == IDLE) & pf_arvalid &
                   (~dem_arvalid | (starve_q == STV_MAX));
      grant_dem  = rst_n & (state_q == IDLE) & dem_arvalid & ~grant_pf;
      cancel_now = (state_q != IDLE) & owner_q & pf_cancel;
      beat_go    = (state_q == DATA) & mem_rvalid;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      owner_d  = owner_q;
      starve_d = starve_q;
      beat_d   = beat_q;
      cancel_d = cancel_q | cancel_now;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            cancel_d = 1'b0;
            if (grant_pf) begin
               addr_d   = pf_araddr;
               owner_d  = 1'b1;
               starve_d = '0;
               state_d  = ADDR;
            end else if (grant_dem) begin
               addr_d  = dem_araddr;
               owner_d = 1'b0;
               if (pf_arvalid && (starve_q != STV_MAX)) begin
                  starve_d = starve_q + STV_W'(1);
               end
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (mem_arready) begin
               beat_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (mem_rvalid) begin
               if (beat_q != {CNT_W{1'b1}}) begin
                  beat_d = beat_q + CNT_W'(1);
               end
               // A short or long burst is still drained to its rlast, but flagged.
               if (mem_rlast) begin
                  if (beat_q != LAST_BEAT) begin
                     err_d = 1'b1;
                  end
                  cancel_d = 1'b0;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         owner_q  <= 1'b0;
         starve_q <= '0;
         beat_q   <= '0;
         cancel_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         beat_q   <= beat_d;
         cancel_q <= cancel_d;
         err_q    <= err_d;
      end
   end

   assign dem_arready = grant_dem;
   assign pf_arready  = grant_pf;
   assign mem_arvalid = (state_q == ADDR);
   assign mem_araddr  = addr_q;
   assign mem_arlen   = 8'(BURST_LEN - 1);
   assign mem_rready  = (state_q == DATA);
   assign busy        = (state_q != IDLE);
   assign owner       = owner_q;
   assign err         = err_q;

   // Cancel suppresses the beat in the very cycle it is raised, hence cancel_now.
   assign dem_rvalid = beat_go & ~owner_q;
   assign pf_rvalid  = beat_go & owner_q & ~(cancel_q | cancel_now);
   assign dem_rdata  = mem_rdata;
   assign pf_rdata   = mem_rdata;
   assign dem_rlast  = dem_rvalid & mem_rlast;
   assign pf_rlast   = pf_rvalid & mem_rlast;

endmodule
